// File: rtl/data_memory_sized_if.sv
// MEM-stage request/response bundle between the pipeline and data_memory_sized.
// The pipeline drives requests through the master modport; the memory answers through the slave modport.
`timescale 1ns/1ps
interface data_memory_sized_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [1:0]        Size;
    logic              Unsigned;
    logic              Ready;
    logic [31:0]       rDataOut;
    logic              rValid;
    logic              AddrErr;

    modport master (
        output Addr, WriteData, MemWrite, MemRead, Size, Unsigned,
        input  Ready, rDataOut, rValid, AddrErr
    );

    modport slave (
        input  Addr, WriteData, MemWrite, MemRead, Size, Unsigned,
        output Ready, rDataOut, rValid, AddrErr
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory: byte/half/word access, sign/zero-extended loads with one-cycle
// registered latency, request error detection, and an optional post-reset clear sequencer.
`timescale 1ns/1ps
module data_memory_sized #(
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    data_memory_sized_if.slave     bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    // Narrow address buses are zero-extended so indexing always has enough bits.
    localparam int AW_EXT = (ADDR_W > IDX_W + 2) ? ADDR_W : IDX_W + 2;

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic              ready_q;
    logic              rvalid_q;
    logic              addr_err_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH];

    logic [AW_EXT-1:0] addr_ext;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              out_of_range;
    logic              misaligned;
    logic              req;
    logic              reject;
    logic              accept_ld;
    logic              accept_st;

    assign addr_ext = AW_EXT'(bus.Addr);
    assign word_idx = addr_ext[IDX_W+1:2];
    assign lane     = addr_ext[1:0];

    generate
        if (AW_EXT > IDX_W + 2) begin : g_range
            assign out_of_range = |addr_ext[AW_EXT-1:IDX_W+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign misaligned = ((bus.Size == 2'b01) && lane[0]) ||
                        ((bus.Size == 2'b10) && (lane != 2'b00));
    assign req        = bus.MemRead | bus.MemWrite;
    assign reject     = (bus.MemRead & bus.MemWrite) | (bus.Size == 2'b11) |
                        misaligned | out_of_range;
    assign accept_ld  = (state == S_IDLE) && req && !reject && bus.MemRead;
    assign accept_st  = (state == S_IDLE) && req && !reject && bus.MemWrite;

    // Load path: select the addressed field and extend it.
    logic [31:0] rd_word;
    logic [31:0] load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rd_word  = mem[word_idx];
        ld_byte  = rd_word[8*lane +: 8];
        ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (bus.Size)
            2'b00:   load_val = bus.Unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_val = bus.Unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_val = rd_word;
        endcase
    end

    // Write port shared by the clear sequencer and accepted stores.
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [IDX_W-1:0] mem_widx;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        mem_widx  = word_idx;
        if (!rst) begin
            if (state == S_INIT) begin
                mem_we   = 1'b1;
                mem_be   = 4'hF;
                mem_widx = clr_cnt;
            end else if (accept_st) begin
                mem_we = 1'b1;
                case (bus.Size)
                    2'b00: begin
                        mem_be    = 4'b0001 << lane;
                        mem_wdata = {4{bus.WriteData[7:0]}};
                    end
                    2'b01: begin
                        mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{bus.WriteData[15:0]}};
                    end
                    default: begin
                        mem_be    = 4'hF;
                        mem_wdata = bus.WriteData;
                    end
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset term; clearing it is the INIT sequencer's job, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
            clr_cnt    <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            case (state)
                S_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    if (req && reject) begin
                        addr_err_q <= 1'b1;
                    end else if (accept_ld) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= load_val;
                    end
                end
            endcase
        end
    end

    assign bus.Ready    = ready_q;
    assign bus.rValid   = rvalid_q;
    assign bus.AddrErr  = addr_err_q;
    assign bus.rDataOut = rdata_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: stimulus pushes expected responses from a byte-array
// reference model; a negedge monitor pops and compares whenever the DUT presents a response.
`timescale 1ns/1ps
module tb_data_memory_sized;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_sized_if #(.ADDR_W(ADDR_W)) bus ();

    data_memory_sized #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  ref_mem [4*DEPTH];
    logic [31:0] last_data;
    bit          in_init;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: any response must match the oldest outstanding expectation, in kind, data and cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && (bus.rValid === 1'b1 || bus.AddrErr === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_response", {30'b0, bus.rValid, bus.AddrErr}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_kind", {30'b0, bus.rValid, bus.AddrErr}, mon_e.is_err ? 32'd1 : 32'd2);
                check("resp_data", bus.rDataOut, mon_e.data);
                check("resp_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'd0: begin
                b = ref_mem[a];
                return uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'd1: begin
                h = {ref_mem[a+1], ref_mem[a]};
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
    endfunction

    task automatic model_req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   bad;
        bad = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
              (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(4 * DEPTH));
        e.due = cyc + 1;
        if (bad) begin
            e.is_err = 1'b1;
            e.data   = last_data;
            sb.push_back(e);
        end else if (wr) begin
            for (int i = 0; i < (1 << sz); i++) ref_mem[a+i] = wd[8*i +: 8];
        end else begin
            last_data = ref_load(a, sz, uns);
            e.is_err  = 1'b0;
            e.data    = last_data;
            sb.push_back(e);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Size      = sz;
        bus.Unsigned  = uns;
        bus.Addr      = a;
        bus.WriteData = wd;
        if (!in_init && (rd || wr)) model_req(rd, wr, sz, uns, a, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.Ready), 32'h0);
        check("reset_rvalid", 32'(bus.rValid), 32'h0);
        check("reset_addrerr", 32'(bus.AddrErr), 32'h0);
        check("reset_rdata", bus.rDataOut, 32'h0);
        rst       = 1'b0;
        last_data = 32'h0;
        in_init   = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) ref_mem[i] = 8'h0;
    endtask

    // Ready is sampled starting right after rst is released; it must stay low for DEPTH cycles.
    task automatic wait_ready(input string name);
        int cnt = 0;
        while (bus.Ready !== 1'b1 && cnt < 3 * DEPTH) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check(name, 32'(cnt), 32'(DEPTH));
        in_init = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          kind;

        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Size = 2'd0;
        bus.Unsigned = 1'b0; bus.Addr = '0; bus.WriteData = 32'h0;

        // Clear sequence
        do_reset(2);
        wait_ready("ready_low_cycles");
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0);

        // Lane merge and extension
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);

        // Error cases, then confirm memory is unchanged
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_5555);
        drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        idle(1);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

        // Streaming word loads
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);

        // Randomized traffic over a small window plus occasional out-of-range addresses
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                idle(1);
            end else begin
                a = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 19) == 0) a = 32'h1000 + 32'($urandom_range(0, 16'hFFFF));
                sz = 2'($urandom_range(0, 2));
                if ($urandom_range(0, 24) == 0) sz = 2'd3;
                kind = int'($urandom_range(0, 19));
                if (kind < 8)       drive(1'b0, 1'b1, sz, 1'($urandom_range(0, 1)), a, $urandom);
                else if (kind < 19) drive(1'b1, 1'b0, sz, 1'($urandom_range(0, 1)), a, 32'h0);
                else                drive(1'b1, 1'b1, sz, 1'b0, a, $urandom);
            end
        end
        idle(3);
        check("queue_drained_before_reset", 32'(sb.size()), 32'h0);

        // Reset in the middle of INIT; requests issued during INIT must be ignored
        do_reset(1);
        for (int n = 0; n < 500; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'b0, 32'($urandom_range(0, 32'h1FFF)), $urandom);
        end
        check("ready_low_mid_init", 32'(bus.Ready), 32'h0);
        do_reset(1);
        wait_ready("ready_low_cycles_after_restart");
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0);
        idle(3);
        check("queue_drained_at_end", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the MIPS-32 data memory.
- Clocked, byte-addressed data memory with byte/halfword/word access, sign/zero extension on loads, and registered 1-cycle read latency.
- Detects misaligned, out-of-range and illegal requests, and runs a post-reset clear sequencer.
- Sits in the MEM stage. The pipeline issues requests only while Ready=1.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two, >= 4.
- ADDR_W, 32, width of byte address input Addr.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = skip clear, contents undefined.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Addr  in  ADDR_W  byte address of the access.
- WriteData  in  32  store data; the low bits carry byte/half stores.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Ready  out  1  high when the block accepts requests.
- rDataOut  out  32  load result, registered.
- rValid  out  1  one-cycle pulse, rDataOut carries a new load result.
- AddrErr  out  1  one-cycle pulse, request in the previous cycle was rejected.

Behaviour:
- Reset (rst=1 at an edge):
  - rDataOut=0, rValid=0, AddrErr=0, Ready=0.
  - State goes to INIT (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0); the clear counter goes to 0.
  - Reset wins over every other input. Reset during INIT restarts the clear from word 0.
- States:
  - INIT: each cycle writes 0 to word[counter] and increments counter. After word DEPTH-1 is written, go to IDLE. INIT lasts exactly DEPTH cycles after rst falls. Ready=0 throughout; MemRead/MemWrite are ignored with no error, no rValid, no write.
  - IDLE: Ready=1. A request is sampled at the rising edge when MemRead or MemWrite is high.
- Word index = Addr[log2(DEPTH)+1:2]; byte lane = Addr[1:0].
- Request is rejected (AddrErr=1 next cycle, no write, rValid=0, rDataOut holds) when any of:
  - MemRead and MemWrite are both high.
  - Size=11.
  - Misalignment: half with Addr[0]=1, or word with Addr[1:0]!=00.
  - Addr >= 4*DEPTH, i.e. any address bit above log2(DEPTH)+1 is set.
- Store (accepted):
  - The word updates at the sampling edge. Only the addressed lanes change.
  - Byte: lane Addr[1:0] <= WriteData[7:0].
  - Half: lanes Addr[1]*2 and Addr[1]*2+1 <= WriteData[15:0] (little-endian).
  - Word: all four lanes <= WriteData.
  - rValid stays 0.
- Load (accepted):
  - Next cycle: rValid=1, and rDataOut = addressed field right-justified and extended per Unsigned. Word loads ignore Unsigned.
  - Read-after-write: a load one cycle after a store to the same word returns the updated data.
- No request, or a rejected request: rDataOut holds its previous value; rValid=0.
- Back-to-back loads: one result per cycle, each rValid pulse aligned with its data.
- Unused high Addr bits above ADDR_W are not checked when ADDR_W <= log2(DEPTH)+2.

Test Plan:
1. Clear sequence: rst high 2 cycles, then low. Ready must be 0 for exactly 1024 cycles, then 1. Word load of 0x0000_0FFC returns 0x0000_0000.
2. Lane merge: word store 0x11223344 @0x10, then byte store 0xAA @0x11, then half store 0xBEEF @0x12. Word load @0x10 returns 0xBEEFAA44, with rValid one cycle after the request.
3. Extension: with 0xBEEFAA44 @0x10, lb @0x11 -> 0xFFFFFFAA. lbu @0x11 -> 0x000000AA. lh @0x12 -> 0xFFFFBEEF. lhu @0x12 -> 0x0000BEEF.
4. Errors: each of the following gives AddrErr pulse=1 with memory unchanged and rDataOut held:
   - word load @0x13
   - half store @0x21
   - Size=11
   - MemRead and MemWrite both high
   - load @0x1000 (DEPTH=1024)
5. Reset mid-INIT: assert rst at clear cycle 500. The clear restarts; Ready rises exactly 1024 cycles after the second rst release. Requests issued during INIT produce no rValid and no AddrErr.
6. Streaming: 4 consecutive word loads @0x0,0x4,0x8,0xC after stores 1,2,3,4. rValid is high 4 consecutive cycles with rDataOut = 1,2,3,4 in order.
